// File: rtl/timer_arbiter.sv
// timer_arbiter: round-robin sharing of one N-bit interval counter among REQ
// requesters. The winner's programmed duration is latched at grant; the count
// runs to duration-1, then a one-cycle done pulse goes to the owner.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no owner; arbitrate among set req bits from the RR pointer
// S_COUNT | owner's count running, q steps 0..limit-1, gnt held
// S_DONE  | completion; done pulse cycle (zero-length grants spend their
//         | gnt cycle here first, then the done cycle)
module timer_arbiter #(
    parameter int N   = 8,
    parameter int REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ-1:0]   req,
    input  logic [REQ*N-1:0] dur,
    output logic [REQ-1:0]   gnt,
    output logic [REQ-1:0]   done,
    output logic             busy,
    output logic [N-1:0]     q
);

    localparam int PW = $clog2(REQ);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_owner, w_owner_nxt;
    logic [PW-1:0]   r_ptr,   w_ptr_nxt;
    logic [N-1:0]    r_limit, w_limit_nxt;
    logic [REQ-1:0]  r_gnt,   w_gnt_nxt;
    logic [REQ-1:0]  r_done,  w_done_nxt;
    logic            r_busy,  w_busy_nxt;
    logic [N-1:0]    r_q,     w_q_nxt;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [N-1:0]    w_win_dur;
    logic [PW-1:0]   w_owner_inc;
    logic [REQ-1:0]  w_owner_oh;

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < REQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % REQ;
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_win   = PW'(idx);
            end
        end
    end

    assign w_win_dur   = dur[int'(w_win)*N +: N];
    assign w_owner_inc = (r_owner == PW'(REQ-1)) ? '0 : r_owner + PW'(1);
    assign w_owner_oh  = REQ'(1) << r_owner;

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_limit_nxt = r_limit;
        w_gnt_nxt   = r_gnt;
        w_done_nxt  = r_done;
        w_busy_nxt  = r_busy;
        w_q_nxt     = r_q;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt  = '0;
                w_done_nxt = '0;
                w_busy_nxt = 1'b0;
                w_q_nxt    = '0;
                if (w_found) begin
                    w_owner_nxt = w_win;
                    w_limit_nxt = w_win_dur;
                    w_gnt_nxt   = REQ'(1) << w_win;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = (w_win_dur != '0) ? S_COUNT : S_DONE;
                end
            end
            S_COUNT: begin
                // An abort wins over reaching the terminal count on the same edge.
                if (!req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_q_nxt     = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else if (r_q == r_limit - N'(1)) begin
                    w_state_nxt = S_DONE;
                    w_gnt_nxt   = '0;
                    w_done_nxt  = w_owner_oh;
                end else begin
                    w_q_nxt = r_q + N'(1);
                end
            end
            S_DONE: begin
                if (r_done != '0) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = '0;
                    w_busy_nxt  = 1'b0;
                    w_q_nxt     = '0;
                    w_ptr_nxt   = w_owner_inc;
                end else begin
                    // Zero-length grant: its gnt cycle is over, raise done next.
                    w_gnt_nxt  = '0;
                    w_done_nxt = w_owner_oh;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
                w_done_nxt  = '0;
                w_busy_nxt  = 1'b0;
                w_q_nxt     = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_limit <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_limit <= w_limit_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_q     <= w_q_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign q    = r_q;

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Shares one N-bit up-counter between REQ requesters, each asking for a timed interval of its own programmed length. A round-robin arbiter grants the counter to one requester at a time. The granted requester's count runs to completion, then a one-cycle done pulse goes to that requester. The block sits in front of the free-running counter datapath and sequences it: it clears the counter, enables it, and terminates it.

## Interface
- N, default 8: counter width; also the width of each duration field.
- REQ, default 4: number of requesters (2..8).
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- req  input  REQ  per-requester level request; must be held until done or abort.
- dur  input  REQ*N  packed durations; requester i uses bits [i*N +: N].
- gnt  output  REQ  one-hot grant; all-zero when no owner.
- done  output  REQ  one-cycle completion pulse to the owner.
- busy  output  1  high while in COUNT or DONE.
- q  output  N  current count value.

## Operation
- State machine: IDLE, COUNT, DONE. All state is registered; outputs come straight from registers.
- Reset (rst=1 at an edge), from any state including mid-count:
  - state goes to IDLE.
  - gnt, done, busy and q all go to 0.
  - The round-robin pointer goes to 0, so req[0] has top priority.
- IDLE:
  - If no req bit is set, remain in IDLE with q=0.
  - Otherwise pick the first set req bit, searching from the pointer upward and wrapping modulo REQ. That requester is the winner w.
  - Latch limit = dur[w], set gnt[w]=1, busy=1, q=0.
  - If limit != 0, go to COUNT.
  - If limit == 0, go directly to DONE.
- COUNT:
  - q increments by 1 at each edge.
  - When q == limit-1 at an edge: go to DONE, clear gnt, set done[w]=1, and hold q at limit-1.
  - No wrap occurs: the maximum limit is 2^N-1, so q never exceeds 2^N-2.
- DONE:
  - Lasts exactly one cycle. done[w] is high and busy stays 1.
  - At the next edge: return to IDLE, clear done, busy and q, and set pointer = (w+1) mod REQ.
- Abort: if req[w] drops while in COUNT, go to IDLE at the next edge with no done pulse.
  - gnt, busy and q go to 0.
  - The pointer still advances to (w+1) mod REQ.
- dur[w] is sampled only at the grant edge. Later changes to dur are ignored for that grant.
- Other requesters' req changes during COUNT or DONE are ignored. They are evaluated in the next IDLE cycle.
- If a requester holds req after its done pulse, it stays eligible, but it now has the lowest priority.
- At most one gnt bit and at most one done bit are ever set, and done[i] implies gnt[i] was set in the preceding cycle.

## Timing
- Grant latency: req sampled high in IDLE at edge t means gnt, busy=1 and q=0 are visible after edge t.
- A duration of D (nonzero) gives D cycles in COUNT, with q showing 0, 1, …, D-1. The done pulse occupies the cycle after the COUNT cycle in which q = D-1.
- A duration of 0 gives a grant cycle and then DONE immediately, so gnt is high for 1 cycle.
- Total occupancy per grant is D+1 cycles from grant to DONE exit. One mandatory IDLE cycle separates consecutive grants.
- Back-to-back arbitration: the earliest new gnt comes 1 cycle after done falls.
- Abort: req[w] sampled low at edge t means gnt, busy and q are all 0 after edge t.

## Test plan
- Single request: N=8, req=0001, dur0=5.
  - gnt[0] high for 5 cycles while q steps 0..4.
  - done[0] pulses in the next cycle with q=4.
  - busy falls the cycle after that.
- Round-robin: req=1111 held, all durations 2.
  - Grants come in order 0,1,2,3,0.
  - Each grant is separated by DONE+IDLE.
  - Exactly one done pulse per grant.
- Zero duration: req=0100, dur2=0.
  - gnt[2] high for 1 cycle, then done[2] for 1 cycle.
  - q stays 0 throughout.
- Abort: req=0010, dur1=10, req[1] dropped while q=3.
  - No done pulse.
  - gnt, busy and q are all 0 the next cycle.
  - A later req=0011 grants requester 0... then requester 1 is next after requester 0, confirming the pointer advanced to 2 and wrapped correctly.
- Reset mid-count: req=1000, dur3=200, rst=1 while q=50.
  - All outputs are 0 after the edge.
  - After rst is released with req=1001, requester 0 is granted first.
- Maximum duration: dur0=255.
  - q reaches 254, then DONE follows with no wrap.
  - A dur change during COUNT does not alter the terminal count.
